// File: rtl/md4_share_arbiter.sv
// Round-robin arbiter that time-shares one MD4 compression core between NREQ lanes.
// Each lane gets a fresh initial state plus its block, and receives the raw A/B/C/D words back.
module md4_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*512-1:0]   req_data,
  output logic [NREQ-1:0]       done,
  output logic [127:0]          result,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  md4_irdy,
  output logic [31:0]           md4_state_a,
  output logic [31:0]           md4_state_b,
  output logic [31:0]           md4_state_c,
  output logic [31:0]           md4_state_d,
  output logic [511:0]          md4_data,
  input  logic                  md4_ordy,
  input  logic [31:0]           md4_out_a,
  input  logic [31:0]           md4_out_b,
  input  logic [31:0]           md4_out_c,
  input  logic [31:0]           md4_out_d
);

  localparam logic [127:0] MD4_IV = 128'h67452301_efcdab89_98badcfe_10325476;

  typedef enum logic [2:0] {
    S_IDLE, S_FIRE1, S_FIRE2, S_FIRE3, S_WAIT, S_DELIVER, S_HOLD
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_done;
  logic [127:0]      r_result;
  logic [IDW-1:0]    r_gid;
  logic [IDW-1:0]    r_last;
  logic              r_busy;
  logic              r_irdy;
  logic [127:0]      r_iv;
  logic [511:0]      r_data;

  logic [511:0]      w_blk [NREQ];
  logic [IDW-1:0]    w_idx;
  logic [IDW-1:0]    w_win;
  logic              w_found;

  for (genvar g = 0; g < NREQ; g++) begin : g_blk
    assign w_blk[g] = req_data[512*g +: 512];
  end

  // Scan last+NREQ down to last+1 so the nearest requester after last wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (r_last >= IDW'(NREQ - k)) ? r_last - IDW'(NREQ - k) : r_last + IDW'(k);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state  <= S_IDLE;
      r_done   <= '0;
      r_result <= '0;
      r_gid    <= '0;
      r_last   <= IDW'(NREQ - 1);
      r_busy   <= 1'b0;
      r_irdy   <= 1'b0;
      r_iv     <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_gid   <= w_win;
          r_busy  <= 1'b1;
          r_data  <= w_blk[w_win];
          r_iv    <= MD4_IV;
          r_state <= S_FIRE1;
        end
        S_FIRE1: begin
          r_irdy  <= 1'b1;
          r_state <= S_FIRE2;
        end
        S_FIRE2: r_state <= S_FIRE3;
        S_FIRE3: begin
          r_irdy  <= 1'b0;
          r_state <= S_WAIT;
        end
        // ordy may still be high from the previous block until here; only WAIT trusts it.
        S_WAIT: if (md4_ordy) begin
          r_result <= {md4_out_a, md4_out_b, md4_out_c, md4_out_d};
          r_state  <= S_DELIVER;
        end
        S_DELIVER: begin
          if (req[r_gid]) begin
            r_done[r_gid] <= 1'b1;
            r_state       <= S_HOLD;
          end else begin
            r_last  <= r_gid;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_HOLD: if (!req[r_gid]) begin
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_last  <= r_gid;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done        = r_done;
  assign result      = r_result;
  assign grant_id    = r_gid;
  assign busy        = r_busy;
  assign md4_irdy    = r_irdy;
  assign md4_state_a = r_iv[127:96];
  assign md4_state_b = r_iv[95:64];
  assign md4_state_c = r_iv[63:32];
  assign md4_state_d = r_iv[31:0];
  assign md4_data    = r_data;

endmodule

// File: tb/tb_md4_share_arbiter.sv
// Bench for md4_share_arbiter: behavioural MD4 core, grant/result scoreboards, directed scenarios.
module tb_md4_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic [127:0] IV    = 128'h67452301_efcdab89_98badcfe_10325476;
  localparam logic [127:0] EMPTY = 128'he0cfd631_31e96ad1_d7593cb7_c089c0e0;

  logic                clk;
  logic                nrst;
  logic [NREQ-1:0]     req;
  logic [NREQ*512-1:0] req_data;
  logic [NREQ-1:0]     done;
  logic [127:0]        result;
  logic [IDW-1:0]      grant_id;
  logic                busy;
  logic                md4_irdy;
  logic [31:0]         md4_state_a, md4_state_b, md4_state_c, md4_state_d;
  logic [511:0]        md4_data;
  logic                md4_ordy;
  logic [31:0]         md4_out_a, md4_out_b, md4_out_c, md4_out_d;

  md4_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_data(req_data),
    .done(done), .result(result), .grant_id(grant_id), .busy(busy),
    .md4_irdy(md4_irdy),
    .md4_state_a(md4_state_a), .md4_state_b(md4_state_b),
    .md4_state_c(md4_state_c), .md4_state_d(md4_state_d),
    .md4_data(md4_data), .md4_ordy(md4_ordy),
    .md4_out_a(md4_out_a), .md4_out_b(md4_out_b),
    .md4_out_c(md4_out_c), .md4_out_d(md4_out_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic int shamt(input int r, input int q);
    case (r)
      0:       return (q == 0) ? 3 : (q == 1) ? 7 : (q == 2) ? 11 : 19;
      1:       return (q == 0) ? 3 : (q == 1) ? 5 : (q == 2) ? 9  : 13;
      default: return (q == 0) ? 3 : (q == 1) ? 9 : (q == 2) ? 11 : 15;
    endcase
  endfunction

  // Reference MD4 compression of one block; word j of the block is m[32*j+:32].
  function automatic logic [127:0] md4f(input logic [511:0] m, input logic [127:0] iv);
    logic [31:0] a, b, c, d, f, k, t;
    int r, j, x;
    a = iv[127:96]; b = iv[95:64]; c = iv[63:32]; d = iv[31:0];
    for (int i = 0; i < 48; i++) begin
      r = i / 16; j = i % 16;
      case (r)
        0: begin f = (b & c) | (~b & d); x = j; k = 32'h0; end
        1: begin f = (b & c) | (b & d) | (c & d); x = (j % 4) * 4 + j / 4; k = 32'h5a827999; end
        default: begin
          f = b ^ c ^ d; k = 32'h6ed9eba1;
          x = ((j & 1) << 3) | ((j & 2) << 1) | ((j & 4) >> 1) | ((j & 8) >> 3);
        end
      endcase
      t = rotl(a + f + m[32*x +: 32] + k, shamt(r, j % 4));
      a = d; d = c; c = b; b = t;
    end
    return {a + iv[127:96], b + iv[95:64], c + iv[63:32], d + iv[31:0]};
  endfunction

  // Core model: latches on irdy rise, drops ordy on the second irdy cycle, answers a few cycles later.
  logic [511:0] c_blk;
  logic [127:0] c_iv;
  logic         c_prev;
  int           c_cnt;
  initial begin
    md4_ordy = 1'b0;
    {md4_out_a, md4_out_b, md4_out_c, md4_out_d} = '0;
    c_prev = 1'b0; c_cnt = 0; c_blk = '0; c_iv = '0;
    forever begin
      @(posedge clk);
      if (md4_irdy && !c_prev) begin
        c_blk = md4_data;
        c_iv  = {md4_state_a, md4_state_b, md4_state_c, md4_state_d};
      end else if (md4_irdy && c_prev) begin
        md4_ordy <= 1'b0;
        c_cnt = $urandom_range(3, 8);
      end else if (c_cnt > 0) begin
        c_cnt--;
        if (c_cnt == 0) begin
          {md4_out_a, md4_out_b, md4_out_c, md4_out_d} <= md4f(c_blk, c_iv);
          md4_ordy <= 1'b1;
        end
      end
      c_prev = md4_irdy;
    end
  end

  int           exp_gnt[$];
  int           exp_lane[$];
  logic [127:0] exp_res[$];
  logic [511:0] lane_blk [NREQ];

  // Monitor: done/result scoreboard, grant order, irdy width and core load contents.
  logic [NREQ-1:0] p_done;
  logic            p_busy, p_irdy;
  int              m_lane, m_ilen;
  initial begin
    p_done = '0; p_busy = 1'b0; p_irdy = 1'b0; m_ilen = 0;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (done != '0) chk("done_1hot", 128'($countones(done)), 128'(1));
        if ((done & ~p_done) != '0) begin
          if (exp_lane.size() == 0) chk("done_unexp", 128'(done), 128'(0));
          else begin
            m_lane = exp_lane.pop_front();
            chk("done_lane", 128'(done), 128'(1) << m_lane);
            chk("result", result, exp_res.pop_front());
          end
        end
        if (busy && !p_busy) begin
          if (exp_gnt.size() == 0) chk("grant_unexp", 128'(grant_id), 128'(0) - 128'(1));
          else chk("grant", 128'(grant_id), 128'(exp_gnt.pop_front()));
        end
        if (md4_irdy) m_ilen++;
        if (md4_irdy && !p_irdy) begin
          chk("init_state", {md4_state_a, md4_state_b, md4_state_c, md4_state_d}, IV);
          chk("core_blk", 128'(md4_data == lane_blk[grant_id]), 128'(1));
        end
        if (!md4_irdy && p_irdy) begin
          chk("irdy_len", 128'(m_ilen), 128'(2));
          m_ilen = 0;
        end
      end
      p_done = done; p_busy = busy; p_irdy = md4_irdy;
    end
  end

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_blk(input int lane, input logic [511:0] blk);
    lane_blk[lane] = blk;
    req_data[512*lane +: 512] = blk;
  endtask

  task automatic expect_txn(input int lane, input logic [127:0] res);
    exp_lane.push_back(lane);
    exp_res.push_back(res);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 128'({done, grant_id, busy, md4_irdy}), 128'(0));
    chk({tag, "_result"}, result, 128'(0));
    chk({tag, "_state"}, {md4_state_a, md4_state_b, md4_state_c, md4_state_d}, 128'(0));
    chk({tag, "_data"}, 128'(|md4_data), 128'(0));
  endtask

  task automatic wait_done(output logic [NREQ-1:0] d);
    int n = 0;
    while (done == '0 && n < 300) begin @(negedge clk); n++; end
    if (done == '0) chk("done_timeout", 128'(0), 128'(1));
    d = done;
  endtask

  task automatic wait_irdy(input logic v);
    int n = 0;
    while (md4_irdy !== v && n < 300) begin @(negedge clk); n++; end
    if (md4_irdy !== v) chk("irdy_timeout", 128'(md4_irdy), 128'(v));
  endtask

  // Lane completes its 4-phase handshake: drop req on done, then one cycle for done to fall.
  task automatic serve(input int n);
    logic [NREQ-1:0] d;
    for (int i = 0; i < n; i++) begin
      wait_done(d);
      req = req & ~d;
      @(negedge clk);
    end
  endtask

  task automatic serve_one(input int lane, input logic [511:0] blk, input logic [127:0] res);
    set_blk(lane, blk);
    exp_gnt.push_back(lane);
    expect_txn(lane, res);
    req[lane] = 1'b1;
    serve(1);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    nrst = 1'b1;
  endtask

  logic [511:0] b;

  initial begin
    nrst = 1'b0; req = '0; req_data = '0;
    for (int i = 0; i < NREQ; i++) lane_blk[i] = '0;
    do_reset();

    // Empty password on lane 0 against the known MD4 digest.
    serve_one(0, 512'h80, EMPTY);
    chk("idle_after_drop", 128'({busy, done}), 128'(0));

    // All lanes from reset: order 0,1,2,3 then 0 again.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_blk(i, rnd512());
    for (int i = 0; i < 5; i++) begin
      exp_gnt.push_back(i % NREQ);
      expect_txn(i % NREQ, md4f(lane_blk[i % NREQ], IV));
    end
    req = '1;
    serve(1);
    req[0] = 1'b1;
    serve(4);

    // After lane 2, lanes 1 and 3 pending: 3 wins first.
    b = rnd512(); serve_one(2, b, md4f(b, IV));
    set_blk(1, rnd512()); set_blk(3, rnd512());
    exp_gnt.push_back(3); expect_txn(3, md4f(lane_blk[3], IV));
    exp_gnt.push_back(1); expect_txn(1, md4f(lane_blk[1], IV));
    req = 4'b1010;
    serve(2);

    // Lane 2 withdraws in WAIT; with last=2 pending lane 3 must beat lane 0.
    b = rnd512(); serve_one(3, b, md4f(b, IV));
    set_blk(2, rnd512()); set_blk(3, rnd512()); set_blk(0, rnd512());
    exp_gnt.push_back(2);
    exp_gnt.push_back(3); expect_txn(3, md4f(lane_blk[3], IV));
    exp_gnt.push_back(0); expect_txn(0, md4f(lane_blk[0], IV));
    req[2] = 1'b1;
    wait_irdy(1'b1);
    req[0] = 1'b1; req[3] = 1'b1;
    wait_irdy(1'b0);
    req[2] = 1'b0;
    serve(2);

    // Reset during WAIT with lane 1 granted, then re-grant with fresh state.
    set_blk(1, rnd512());
    exp_gnt.push_back(1); exp_gnt.push_back(1);
    expect_txn(1, md4f(lane_blk[1], IV));
    req[1] = 1'b1;
    wait_irdy(1'b1);
    wait_irdy(1'b0);
    nrst = 1'b0;
    @(negedge clk);
    chk_zero("rst_wait");
    nrst = 1'b1;
    serve(1);

    repeat (5) @(negedge clk);
    chk("sb_drained", 128'(exp_gnt.size() + exp_lane.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/md4_share_arbiter.md
Name: md4_share_arbiter

Overview:
- Shares one md4block compression core between NREQ independent cracking lanes. Each lane owns its own password incrementer and hashchecker.
- Each lane presents a prepared 512-bit MD4 data block. The arbiter grants the core round-robin, loads the MD4 initial state, sequences the irdy/ordy handshake, and returns the raw A/B/C/D words to the granted lane.
- Byteswapping to hash form stays in the lane.

Parameters:
NREQ, 4, number of requesting lanes (legal 2..8)
IDW, 2, width of lane index; must equal ceil(log2(NREQ)), minimum 1

Ports:
clk  input  1  clock
nrst  input  1  synchronous active-low reset
req  input  NREQ  per-lane request level; held until that lane's done is seen
req_data  input  NREQ*512  lane i block at bits [512*i+511:512*i]
done  output  NREQ  per-lane result-valid level (4-phase)
result  output  128  {A,B,C,D} from core, A in [127:96]; valid while any done bit is high
grant_id  output  IDW  lane currently owning the core
busy  output  1  core owned by a lane
md4_irdy  output  1  core start strobe
md4_state_a / md4_state_b / md4_state_c / md4_state_d  output  32 each  initial state to core
md4_data  output  512  block to core
md4_ordy  input  1  core result-ready level
md4_out_a / md4_out_b / md4_out_c / md4_out_d  input  32 each  core result

Behaviour:
- Reset (clk edge with nrst=0) clears all of the following, including mid-operation: done=0, result=0, grant_id=0, busy=0, md4_irdy=0, md4_state_*=0, md4_data=0, state=IDLE, rr pointer last=NREQ-1 (lane 0 has first priority). A core computation in flight at reset is abandoned; no done is issued.
- IDLE:
  - Winner = first i with req[i]=1, searched in order last+1, last+2, ... mod NREQ.
  - If a winner exists, in the same edge: grant_id<=winner; busy<=1; md4_data<=req_data slice; md4_state_a..d<=67452301, EFCDAB89, 98BADCFE, 10325476 → FIRE1.
- FIRE1: md4_irdy<=1 → FIRE2.
- FIRE2: hold md4_irdy=1 → FIRE3.
  - md4_irdy is high exactly 2 cycles, rising 2 edges after the IDLE cycle that saw req.
- FIRE3: md4_irdy<=0 → WAIT.
- WAIT: when md4_ordy=1, result<={md4_out_a,b,c,d} → DELIVER. md4_ordy is ignored in all other states.
- DELIVER:
  - If req[grant_id]=1: done[grant_id]<=1 → HOLD.
  - Otherwise (lane withdrew): result discarded, no done, last<=grant_id, busy<=0 → IDLE.
- HOLD: keep done and result stable until req[grant_id]=0. Then done<=0, busy<=0, last<=grant_id → IDLE.
- A new grant is never issued before the previous done has fallen. At most one done bit is high at any time.
- md4_data and md4_state_* stay stable from grant until the next grant. A lane may change req_data after done rises.
- Requests arriving or dropping for non-granted lanes during a transaction have no effect until IDLE.
- Simultaneous requests are served strictly round-robin. With all lanes requesting continuously, each lane gets one grant per NREQ transactions.
- Withdrawal before WAIT completes: the core is still allowed to finish; the result is dropped in DELIVER.
- Overhead per transaction excluding core latency: IDLE, FIRE1-3, DELIVER, plus one HOLD cycle minimum = 6 cycles. Back-to-back grants are at least 1 IDLE cycle apart.

Test Plan:
- Single request, lane 0 only, req_data = MD4 block of empty password → md4_irdy high 2 cycles; done[0] rises; result = {md4_out words} matching core. For the empty string, byteswapped result = 31d6cfe0d16ae931b73c59d7e0c089c0. Lane 0 drops req → done falls; busy=0.
- All 4 lanes request from reset and hold → grant order 0,1,2,3,0; each done only on its own lane; no two done bits high together.
- Lanes 1 and 3 request after lane 2 was last served → lane 3 granted first, then 1.
- Lane 2 granted, drops req during WAIT → no done pulse; the next pending lane is granted after the core finishes; last=2.
- nrst low during WAIT with lane 1 granted → next edge: all outputs 0, state IDLE. After release with req[1]=1, lane 0 not requesting → lane 1 re-granted with fresh initial state 67452301/EFCDAB89/98BADCFE/10325476.
- md4_ordy held high during FIRE1-FIRE3 (stale from previous block) → ignored; result captured only from WAIT sampling.
